// File: rtl/seq_pkg.sv
// seq_pkg: state encodings and shared constants for the multicycle sequencer.
package seq_pkg;
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_t;
  localparam int MEM_TIMEOUT_DEFAULT = 255;
  localparam int WAIT_W = 8;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled request cycles and flags the cycle the limit is reached.
module mem_wait_timer import seq_pkg::*; (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic [WAIT_W-1:0] i_limit,
  output logic              o_expired
);
  logic [WAIT_W-1:0] r_count;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_enable) r_count <= r_count + 1'b1;
  // Expires in the stalled cycle that would bring the count up to the limit.
  assign o_expired = i_enable && (r_count == i_limit - 1'b1);
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/execute/memory/writeback control FSM with memory timeout.
module multicycle_sequencer import seq_pkg::*; #(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int RETIRE_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_halt,
  input  logic                i_dmem_read_enable,
  input  logic                i_dmem_write_enable,
  input  logic                i_reg_write_enable,
  input  logic                i_mem_ready,
  output logic                o_mem_req,
  output logic                o_mem_is_fetch,
  output logic                o_mem_we,
  output logic                o_ir_load,
  output logic                o_pc_write,
  output logic                o_reg_write,
  output logic                o_retire,
  output logic                o_halted,
  output logic                o_fault,
  output logic [2:0]          o_state,
  output logic [RETIRE_W-1:0] o_retire_count
);
  state_t              r_state;
  logic                r_fault;
  logic [RETIRE_W-1:0] r_retire_count;
  logic                w_in_fetch, w_in_mem, w_in_wb, w_pending, w_expired;
  assign w_in_fetch = r_state == S_FETCH;
  assign w_in_mem   = r_state == S_MEMORY;
  assign w_in_wb    = r_state == S_WRITEBACK;
  assign w_pending  = w_in_fetch | w_in_mem;
  // Outside a request, or once it completes, the counter is held at zero so each new request starts fresh.
  mem_wait_timer u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (~w_pending | i_mem_ready),
    .i_enable  (w_pending & ~i_mem_ready),
    .i_limit   (WAIT_W'(MEM_TIMEOUT)),
    .o_expired (w_expired)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state        <= S_FETCH;
      r_fault        <= 1'b0;
      r_retire_count <= '0;
    end else if (w_expired) begin
      r_state <= S_HALTED;
      r_fault <= 1'b1;
    end else begin
      case (r_state)
        S_FETCH:     if (i_mem_ready) r_state <= S_DECODE;
        S_DECODE:    r_state <= i_halt ? S_HALTED : S_EXECUTE;
        S_EXECUTE:   r_state <= (i_dmem_read_enable | i_dmem_write_enable) ? S_MEMORY : S_WRITEBACK;
        S_MEMORY:    if (i_mem_ready) r_state <= S_WRITEBACK;
        S_WRITEBACK: begin
          r_state        <= S_FETCH;
          r_retire_count <= r_retire_count + 1'b1;
        end
        default:     r_state <= S_HALTED;
      endcase
    end
  assign o_state        = r_state;
  assign o_halted       = r_state == S_HALTED;
  assign o_fault        = r_fault;
  assign o_retire_count = r_retire_count;
  // Reset state is FETCH, so request and strobes are masked while reset is held.
  assign o_mem_req      = w_pending & ~i_rst;
  assign o_mem_is_fetch = w_in_fetch & ~i_rst;
  assign o_mem_we       = w_in_mem & i_dmem_write_enable & ~i_rst;
  assign o_ir_load      = w_in_fetch & i_mem_ready & ~i_rst;
  assign o_pc_write     = w_in_wb & ~i_rst;
  assign o_retire       = w_in_wb & ~i_rst;
  assign o_reg_write    = w_in_wb & i_reg_write_enable & ~i_rst;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: instruction-level reference model driving directed and random instruction streams.
module tb_multicycle_sequencer;
  localparam int T = 4;
  localparam int RW = 4;
  logic i_clk = 0, i_rst = 1, i_halt = 0, i_dmem_read_enable = 0, i_dmem_write_enable = 0;
  logic i_reg_write_enable = 0, i_mem_ready = 0;
  logic o_mem_req, o_mem_is_fetch, o_mem_we, o_ir_load, o_pc_write, o_reg_write, o_retire, o_halted, o_fault;
  logic [2:0] o_state;
  logic [RW-1:0] o_retire_count;
  int total = 0, bad = 0, m_cnt = 0;
  bit m_fault = 0;

  multicycle_sequencer #(.MEM_TIMEOUT(T), .RETIRE_W(RW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_halt(i_halt),
    .i_dmem_read_enable(i_dmem_read_enable), .i_dmem_write_enable(i_dmem_write_enable),
    .i_reg_write_enable(i_reg_write_enable), .i_mem_ready(i_mem_ready),
    .o_mem_req(o_mem_req), .o_mem_is_fetch(o_mem_is_fetch), .o_mem_we(o_mem_we),
    .o_ir_load(o_ir_load), .o_pc_write(o_pc_write), .o_reg_write(o_reg_write),
    .o_retire(o_retire), .o_halted(o_halted), .o_fault(o_fault),
    .o_state(o_state), .o_retire_count(o_retire_count)
  );

  always #5 i_clk = ~i_clk;

  wire [10:0] w_obs = {o_state, o_mem_req, o_mem_is_fetch, o_mem_we, o_ir_load,
                       o_pc_write, o_reg_write, o_retire, o_halted, o_fault};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] vec(input int st, input bit mreq, isf, we, irl, pcw, rw, ret);
    return {3'(st), mreq, isf, we, irl, pcw, rw, ret, st == 5, m_fault};
  endfunction

  task automatic cyc(input string tag, input bit rdy, input logic [10:0] exp);
    i_mem_ready = rdy;
    @(negedge i_clk);
    check(tag, 32'(w_obs), 32'(exp));
    check({tag, "_cnt"}, 32'(o_retire_count), 32'(m_cnt % 16));
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_rst = 1;
    #2;
    check("rst_outs", 32'(w_obs), 0);
    check("rst_cnt", 32'(o_retire_count), 0);
    @(posedge i_clk);
    #1;
    i_rst = 0;
    m_cnt = 0;
    m_fault = 0;
  endtask

  task automatic run_instr(input int wf, input bit h, rd, wr, rwe, input int wm, output bit stopped);
    i_halt = h;
    i_dmem_read_enable = rd;
    i_dmem_write_enable = wr;
    i_reg_write_enable = rwe;
    stopped = 1;
    for (int k = 0; k < wf && k < T; k++) cyc("fetch_wait", 0, vec(0, 1, 1, 0, 0, 0, 0, 0));
    if (wf >= T) begin m_fault = 1; return; end
    cyc("fetch_rdy", 1, vec(0, 1, 1, 0, 1, 0, 0, 0));
    cyc("decode", 1'($urandom_range(0, 1)), vec(1, 0, 0, 0, 0, 0, 0, 0));
    if (h) return;
    cyc("execute", 1'($urandom_range(0, 1)), vec(2, 0, 0, 0, 0, 0, 0, 0));
    if (rd | wr) begin
      for (int k = 0; k < wm && k < T; k++) cyc("mem_wait", 0, vec(3, 1, 0, wr, 0, 0, 0, 0));
      if (wm >= T) begin m_fault = 1; return; end
      cyc("mem_rdy", 1, vec(3, 1, 0, wr, 0, 0, 0, 0));
    end
    cyc("writeback", 1'($urandom_range(0, 1)), vec(4, 0, 0, 0, 0, 1, rwe, 1));
    m_cnt++;
    stopped = 0;
  endtask

  task automatic hold_halted(input int n);
    for (int k = 0; k < n; k++) begin
      i_halt = 1'($urandom_range(0, 1));
      i_dmem_read_enable = 1'($urandom_range(0, 1));
      i_dmem_write_enable = 1'($urandom_range(0, 1));
      i_reg_write_enable = 1'($urandom_range(0, 1));
      cyc("halted", 1'($urandom_range(0, 1)), vec(5, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s;
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 1, 0, s);
    check("alu3_cnt", 32'(o_retire_count), 3);
    run_instr(0, 0, 0, 1, 0, 3, s);
    run_instr(0, 0, 1, 0, 1, 0, s);
    run_instr(0, 0, 1, 1, 1, 1, s);
    for (int i = 0; i < 11; i++) run_instr(0, 0, 0, 0, 0, 0, s);
    check("wrap_cnt", 32'(o_retire_count), 1);
    run_instr(3, 0, 0, 0, 1, 0, s);
    check("late_rdy_fault", 32'(o_fault), 0);
    run_instr(4, 0, 0, 0, 1, 0, s);
    check("fetch_to_fault", 32'(o_fault), 1);
    hold_halted(20);
    do_reset();
    run_instr(0, 0, 0, 0, 1, 0, s);
    run_instr(0, 1, 0, 0, 1, 0, s);
    hold_halted(20);
    do_reset();
    run_instr(0, 0, 1, 0, 1, 5, s);
    hold_halted(5);
    do_reset();
    run_instr(0, 0, 0, 0, 1, 0, s);
    run_instr(0, 0, 0, 0, 1, 0, s);
    i_dmem_read_enable = 1;
    i_halt = 0;
    cyc("pre_rst_fetch", 1, vec(0, 1, 1, 0, 1, 0, 0, 0));
    cyc("pre_rst_decode", 0, vec(1, 0, 0, 0, 0, 0, 0, 0));
    cyc("pre_rst_execute", 0, vec(2, 0, 0, 0, 0, 0, 0, 0));
    cyc("pre_rst_mem", 0, vec(3, 1, 0, 0, 0, 0, 0, 0));
    do_reset();
    run_instr(0, 0, 0, 0, 1, 0, s);
    for (int i = 0; i < 60; i++) begin
      int wf, wm;
      wf = ($urandom_range(0, 15) == 0) ? T : int'($urandom_range(0, 2));
      wm = ($urandom_range(0, 15) == 0) ? T : int'($urandom_range(0, 3));
      run_instr(wf, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), wm, s);
      if (s) begin
        hold_halted(3);
        do_reset();
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, is the maximum number of cycles a memory request may wait for i_mem_ready (legal range 1..255).
REQ-002 Parameter RETIRE_W, default 32, is the width of the retired-instruction counter.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_halt  input  1  decoded halt indication for the instruction held in the instruction register.
REQ-006 i_dmem_read_enable  input  1  current instruction is a load.
REQ-007 i_dmem_write_enable  input  1  current instruction is a store.
REQ-008 i_reg_write_enable  input  1  current instruction writes the register file.
REQ-009 i_mem_ready  input  1  memory completes the current request this cycle.
REQ-010 o_mem_req  output  1  memory request active.
REQ-011 o_mem_is_fetch  output  1  the active request is an instruction fetch (1) or a data access (0).
REQ-012 o_mem_we  output  1  the active data request is a write.
REQ-013 o_ir_load  output  1  load the instruction register this cycle.
REQ-014 o_pc_write  output  1  update the PC this cycle.
REQ-015 o_reg_write  output  1  gated register-file write strobe.
REQ-016 o_retire  output  1  one-cycle pulse when an instruction completes.
REQ-017 o_halted  output  1  the sequencer is stopped in HALTED.
REQ-018 o_fault  output  1  sticky memory-timeout flag.
REQ-019 o_state  output  3  current state encoding, for debug.
REQ-020 o_retire_count  output  RETIRE_W  number of retired instructions.

Function
REQ-021 The sequencer SHALL have six states: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALTED=5.
REQ-022 FETCH SHALL assert o_mem_req=1, o_mem_is_fetch=1, o_mem_we=0, and hold those values until i_mem_ready=1.
  - In the cycle i_mem_ready=1: o_ir_load=1 in that same cycle; next state DECODE.
REQ-023 DECODE SHALL last exactly one cycle.
  - Next state HALTED if i_halt=1, otherwise EXECUTE.
REQ-024 EXECUTE SHALL last exactly one cycle.
  - Next state MEMORY if i_dmem_read_enable or i_dmem_write_enable is 1, otherwise WRITEBACK.
REQ-025 MEMORY SHALL assert o_mem_req=1, o_mem_is_fetch=0, o_mem_we=i_dmem_write_enable.
  - If both read and write enables are 1, the write takes priority: o_mem_we=1.
  - On i_mem_ready=1: next state WRITEBACK.
REQ-026 WRITEBACK SHALL last one cycle and drive o_pc_write=1, o_retire=1, o_reg_write=i_reg_write_enable.
  - o_retire_count increments by 1, wrapping modulo 2^RETIRE_W.
  - Next state FETCH.
REQ-027 o_reg_write, o_pc_write, o_ir_load and o_retire SHALL be 0 in every state other than the one named above.
REQ-028 Minimum instruction latency SHALL be 4 cycles (non-memory, zero-wait fetch) and 5 cycles for a zero-wait load or store.
REQ-029 A wait counter SHALL clear on entry to FETCH or MEMORY and increment each cycle the request is pending without i_mem_ready.
  - If it reaches MEM_TIMEOUT: o_fault=1 (sticky), o_mem_req drops next cycle, next state HALTED.
  - i_mem_ready in the same cycle the timeout is reached SHALL win: normal transition, no fault.
REQ-030 HALTED SHALL be absorbing until reset.
  - o_halted=1, o_mem_req=0, all strobes 0, o_retire_count frozen.
REQ-031 o_state, o_halted, o_mem_req, o_mem_is_fetch and o_fault SHALL be functions of registered state only.
  - o_ir_load and o_mem_we MAY depend combinationally on inputs as stated above.

Reset
REQ-032 Asserting i_rst SHALL immediately force: state FETCH, wait counter 0, o_retire_count 0, o_fault 0, o_halted 0.
  - All strobes SHALL be 0 while i_rst=1.
REQ-033 Reset asserted mid-request SHALL abandon the request without a retire; the first cycle after deassertion is a fresh FETCH with o_mem_req=1.

Structure
REQ-034 State encodings and the default MEM_TIMEOUT SHALL live in the shared package seq_pkg.
REQ-035 The wait counter and timeout compare SHALL be a sub-module named mem_wait_timer (inputs: clear, enable, limit; output: expired).

Verification
REQ-036 ALU instruction, i_mem_ready tied 1 -> states 0,1,2,4,0; o_retire pulses once per 4 cycles; o_retire_count=3 after 12 cycles.
REQ-037 Store with ready after 3 wait cycles in MEMORY -> o_mem_we=1 for 4 cycles, then WRITEBACK; o_reg_write=0 with i_reg_write_enable=0.
REQ-038 i_halt=1 in DECODE -> HALTED next cycle; o_halted=1, o_mem_req=0, o_retire_count unchanged for 20 further cycles.
REQ-039 MEM_TIMEOUT=4, i_mem_ready held 0 in FETCH -> o_fault=1 and HALTED after 4 wait cycles; ready arriving in the 4th cycle -> no fault.
REQ-040 i_rst pulsed while in MEMORY -> outputs zero immediately; after release, FETCH with o_retire_count=0 and o_fault=0.
REQ-041 RETIRE_W=4, run 17 instructions -> o_retire_count wraps to 1.
